// File: rtl/cdec_mem_arbiter_pkg.sv
// Shared constants, state encoding and status-byte packing for the CDEC8
// external memory bus arbiter.
package cdec_mem_arbiter_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Access sequencer states; the encoding is visible on the status byte.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } arb_state_t;

  localparam logic [7:0] RES_ADR_DEFAULT = 8'h0D;
  localparam logic [1:0] CS_ACTIVE       = 2'b10;
  localparam logic [1:0] CS_IDLE         = 2'b11;
  localparam logic [3:0] BE_NONE         = 4'b1111;

  // Debug status byte as seen on the resource bus (strobes shown active-high).
  function automatic logic [7:0] status_byte(
    input arb_state_t st,
    input logic       last,
    input logic       busy,
    input logic       p1_req,
    input logic       p0_req,
    input logic       rd_n,
    input logic       wr_n
  );
    return {st, last, busy, p1_req, p0_req, ~rd_n, ~wr_n};
  endfunction

endpackage

// File: rtl/cdec_mem_arbiter_if.sv
// Requester and memory-pin bundle shared by the core, the debug monitor and
// the board memory. The arbiter uses the slave view; everything around it
// (requesters plus memory read data) uses the master view.
interface cdec_mem_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 32
);

  logic          p0_req,   p1_req;
  logic          p0_we,    p1_we;
  logic [AW-1:0] p0_adrs,  p1_adrs;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic [3:0]    p0_be_N,  p1_be_N;
  logic          p0_ack,   p1_ack;
  logic [DW-1:0] p0_rdata, p1_rdata;

  logic [AW-1:0] adrs;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_in;
  logic [1:0]    mmcs_N;
  logic [3:0]    mmbe_N;
  logic          mmrd_N;
  logic          mmwr_N;
  logic          mm_dboe;
  logic          busy;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_adrs, p1_adrs,
           p0_wdata, p1_wdata, p0_be_N, p1_be_N, data_in,
    output p0_ack, p1_ack, p0_rdata, p1_rdata, adrs, data_out,
           mmcs_N, mmbe_N, mmrd_N, mmwr_N, mm_dboe, busy
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_adrs, p1_adrs,
           p0_wdata, p1_wdata, p0_be_N, p1_be_N, data_in,
    input  p0_ack, p1_ack, p0_rdata, p1_rdata, adrs, data_out,
           mmcs_N, mmbe_N, mmrd_N, mmwr_N, mm_dboe, busy
  );

endinterface

// File: rtl/cdec_mem_arbiter_rr.sv
// Two-way round-robin grant. Purely combinational; the parent owns and
// updates the "last granted" bit.
module mem_arb_rr (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic valid_o,
  output logic gnt_o
);

  // On a tie, favour the port that was not granted last.
  always_comb begin
    valid_o = req0_i | req1_i;
    gnt_o   = 1'b0;
    if (req0_i && req1_i) begin
      gnt_o = ~last_i;
    end else if (req1_i) begin
      gnt_o = 1'b1;
    end else begin
      gnt_o = 1'b0;
    end
  end

endmodule

// File: rtl/cdec_mem_arbiter.sv
// Shares the external memory bus between the CDEC8 core (port 0) and the
// debug monitor (port 1), running a setup / strobe(STB cycles) / hold access
// cycle. Every bus and handshake output is registered; only the debug status
// byte is combinational.
module cdec_mem_arbiter
  import cdec_mem_arbiter_pkg::*;
#(
  parameter int         AW      = 19,
  parameter int         DW      = 32,
  parameter int         STB     = 2,
  parameter logic [7:0] RES_ADR = RES_ADR_DEFAULT
) (
  input  logic                clock,
  input  logic                reset_N,
  cdec_mem_arbiter_if.slave   bus,
  input  logic [7:0]          resad,
  output wire  [7:0]          resdt
);

  // Strobe counter runs 0..STB-1 inside STROBE.
  localparam logic [3:0] CNT_LAST = 4'(STB - 1);

  arb_state_t    state_q;
  logic [3:0]    cnt_q;
  logic          last_q;
  logic          gnt_q;
  logic          we_q;
  logic [AW-1:0] adrs_q;
  logic [DW-1:0] data_out_q;
  logic [1:0]    mmcs_q;
  logic [3:0]    mmbe_q;
  logic          mmrd_q;
  logic          mmwr_q;
  logic          dboe_q;
  logic          busy_q;
  logic          ack0_q;
  logic          ack1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  logic          req_valid_s;
  logic          gnt_s;
  logic          win_we_s;
  logic [AW-1:0] win_adrs_s;
  logic [DW-1:0] win_wdata_s;
  logic [3:0]    win_be_s;

  mem_arb_rr u_rr (
    .req0_i  (bus.p0_req),
    .req1_i  (bus.p1_req),
    .last_i  (last_q),
    .valid_o (req_valid_s),
    .gnt_o   (gnt_s)
  );

  // Select the request fields of the port the round-robin picked.
  always_comb begin
    win_we_s    = bus.p0_we;
    win_adrs_s  = bus.p0_adrs;
    win_wdata_s = bus.p0_wdata;
    win_be_s    = bus.p0_be_N;
    if (gnt_s) begin
      win_we_s    = bus.p1_we;
      win_adrs_s  = bus.p1_adrs;
      win_wdata_s = bus.p1_wdata;
      win_be_s    = bus.p1_be_N;
    end else begin
      win_we_s    = bus.p0_we;
      win_adrs_s  = bus.p0_adrs;
      win_wdata_s = bus.p0_wdata;
      win_be_s    = bus.p0_be_N;
    end
  end

  // Access sequencer: arbitrate in IDLE, then drive setup/strobe/hold with
  // all bus outputs registered. Address/enables go live on entry to SETUP and
  // are withdrawn on exit from HOLD, framing the strobe by one cycle each side.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      last_q     <= HIGH;
      gnt_q      <= LOW;
      we_q       <= LOW;
      adrs_q     <= '0;
      data_out_q <= '0;
      mmcs_q     <= CS_IDLE;
      mmbe_q     <= BE_NONE;
      mmrd_q     <= HIGH;
      mmwr_q     <= HIGH;
      dboe_q     <= LOW;
      busy_q     <= LOW;
      ack0_q     <= LOW;
      ack1_q     <= LOW;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack0_q <= LOW;
          ack1_q <= LOW;
          if (req_valid_s) begin
            gnt_q   <= gnt_s;
            we_q    <= win_we_s;
            adrs_q  <= win_adrs_s;
            mmbe_q  <= win_be_s;
            mmcs_q  <= CS_ACTIVE;
            dboe_q  <= win_we_s;
            busy_q  <= HIGH;
            state_q <= ST_SETUP;
            if (win_we_s) begin
              data_out_q <= win_wdata_s;
            end else begin
              data_out_q <= data_out_q;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          cnt_q   <= 4'd0;
          state_q <= ST_STROBE;
          if (we_q) begin
            mmwr_q <= LOW;
          end else begin
            mmrd_q <= LOW;
          end
        end
        ST_STROBE: begin
          if (cnt_q == CNT_LAST) begin
            mmrd_q  <= HIGH;
            mmwr_q  <= HIGH;
            state_q <= ST_HOLD;
            if (gnt_q) begin
              ack1_q <= HIGH;
            end else begin
              ack0_q <= HIGH;
            end
            if (!we_q && gnt_q) begin
              rdata1_q <= bus.data_in;
            end else if (!we_q) begin
              rdata0_q <= bus.data_in;
            end else begin
              rdata0_q <= rdata0_q;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_HOLD: begin
          ack0_q  <= LOW;
          ack1_q  <= LOW;
          mmcs_q  <= CS_IDLE;
          mmbe_q  <= BE_NONE;
          dboe_q  <= LOW;
          busy_q  <= LOW;
          last_q  <= gnt_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.p0_ack   = ack0_q;
  assign bus.p1_ack   = ack1_q;
  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_rdata = rdata1_q;
  assign bus.adrs     = adrs_q;
  assign bus.data_out = data_out_q;
  assign bus.mmcs_N   = mmcs_q;
  assign bus.mmbe_N   = mmbe_q;
  assign bus.mmrd_N   = mmrd_q;
  assign bus.mmwr_N   = mmwr_q;
  assign bus.mm_dboe  = dboe_q;
  assign bus.busy     = busy_q;

  // Status byte is only driven while the debug bus addresses this block.
  assign resdt = (resad == RES_ADR)
               ? status_byte(state_q, last_q, busy_q, bus.p1_req, bus.p0_req, mmrd_q, mmwr_q)
               : 8'hZZ;

endmodule

// File: tb/tb_cdec_mem_arbiter.sv
// Directed bench for cdec_mem_arbiter: single reads/writes, round-robin
// under contention, reset mid-strobe, status byte, and STB=1 / STB=15 builds.
module tb_cdec_mem_arbiter;

  logic clock;
  logic reset_N;
  logic [7:0] resad;
  tri   [7:0] resdt_w;
  tri   [7:0] resdt1_w;
  tri   [7:0] resdt15_w;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_word;

  cdec_mem_arbiter_if #(.AW(19), .DW(32)) b   ();
  cdec_mem_arbiter_if #(.AW(19), .DW(32)) b1  ();
  cdec_mem_arbiter_if #(.AW(19), .DW(32)) b15 ();

  cdec_mem_arbiter #(.AW(19), .DW(32), .STB(2)) dut (
    .clock (clock), .reset_N (reset_N), .bus (b.slave), .resad (resad), .resdt (resdt_w)
  );
  cdec_mem_arbiter #(.AW(19), .DW(32), .STB(1)) dut1 (
    .clock (clock), .reset_N (reset_N), .bus (b1.slave), .resad (8'h00), .resdt (resdt1_w)
  );
  cdec_mem_arbiter #(.AW(19), .DW(32), .STB(15)) dut15 (
    .clock (clock), .reset_N (reset_N), .bus (b15.slave), .resad (8'h00), .resdt (resdt15_w)
  );

  // Undriven debug bus reads back as all ones.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (resdt_w[gi]);
  end

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Byte-lane memory model: stores on each strobed write cycle.
  always @(posedge clock) begin
    if (!b.mmwr_N && b.mmcs_N == 2'b10) begin
      for (int i = 0; i < 4; i++) begin
        if (!b.mmbe_N[i]) mem_word[i*8 +: 8] <= b.data_out[i*8 +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    b.p0_req = 1'b0; b.p1_req = 1'b0; b.p0_we = 1'b0; b.p1_we = 1'b0;
    b.p0_adrs = 19'd0; b.p1_adrs = 19'd0; b.p0_wdata = 32'd0; b.p1_wdata = 32'd0;
    b.p0_be_N = 4'hF; b.p1_be_N = 4'hF;
  endtask

  initial begin
    logic [4:0] dboe_v, wrlo_v, ack1_v;
    int   nack;
    int   ack_port [4];
    int   ack_cyc  [4];
    int   lat1, lat15, acks_seen;

    reset_N  = 1'b0;
    resad    = 8'h00;
    mem_word = 32'd0;
    idle_inputs();
    b.data_in = 32'd0;
    b1.p0_req = 1'b0; b1.p1_req = 1'b0; b1.p0_we = 1'b0; b1.p1_we = 1'b0;
    b1.p0_adrs = 19'd0; b1.p1_adrs = 19'd0; b1.p0_wdata = 32'd0; b1.p1_wdata = 32'd0;
    b1.p0_be_N = 4'hF; b1.p1_be_N = 4'hF; b1.data_in = 32'h0000_0011;
    b15.p0_req = 1'b0; b15.p1_req = 1'b0; b15.p0_we = 1'b0; b15.p1_we = 1'b0;
    b15.p0_adrs = 19'd0; b15.p1_adrs = 19'd0; b15.p0_wdata = 32'd0; b15.p1_wdata = 32'd0;
    b15.p0_be_N = 4'hF; b15.p1_be_N = 4'hF; b15.data_in = 32'h0000_0022;

    // ---- reset state ----
    tick(); tick();
    check_eq("rst_mmcs", b.mmcs_N, 2'b11);
    check_eq("rst_mmbe", b.mmbe_N, 4'b1111);
    check_eq("rst_strobes", {b.mmrd_N, b.mmwr_N, b.mm_dboe}, 3'b110);
    check_eq("rst_busy_ack", {b.busy, b.p0_ack, b.p1_ack}, 3'b000);
    check_eq("rst_adrs_dout", {b.adrs, b.data_out}, 51'd0);
    check_eq("rst_rdata", {b.p0_rdata, b.p1_rdata}, 64'd0);
    reset_N = 1'b1;
    tick();
    resad = 8'h0D; #1;
    check_eq("rst_status", resdt_w, 8'h20);
    resad = 8'h00;

    // ---- port 0 read of 0x00012 returning 0xA5 ----
    b.data_in = 32'h0000_00A5;
    b.p0_we = 1'b0; b.p0_adrs = 19'h00012; b.p0_be_N = 4'b0000; b.p0_req = 1'b1;
    tick();
    check_eq("rd_setup_bus", {b.busy, b.mmcs_N, b.mmrd_N, b.mm_dboe}, 5'b1_10_1_0);
    check_eq("rd_setup_adrs", b.adrs, 19'h00012);
    tick();
    check_eq("rd_strobe1", {b.mmrd_N, b.mmwr_N}, 2'b01);
    resad = 8'h0D; #1;
    check_eq("status_strobe", resdt_w, 8'hB6);
    resad = 8'h0C; #1;
    check_eq("status_unsel", resdt_w, 8'hFF);
    resad = 8'h00;
    tick();
    check_eq("rd_strobe2", {b.mmrd_N, b.mmwr_N}, 2'b01);
    tick();
    check_eq("rd_hold_ack", {b.p0_ack, b.p1_ack, b.mmrd_N, b.mmcs_N}, 5'b1_0_1_10);
    check_eq("rd_rdata", b.p0_rdata, 32'h0000_00A5);
    b.p0_req = 1'b0;
    b.data_in = 32'h5A5A_5A5A;
    tick();
    check_eq("rd_idle", {b.p0_ack, b.busy, b.mmcs_N, b.mmbe_N}, 8'b0_0_11_1111);
    resad = 8'h0D; #1;
    check_eq("status_last0", resdt_w, 8'h00);
    resad = 8'h00;

    // ---- port 1 write 0xDEADBEEF to 0x7FFFF, be_N 1110 ----
    b.p1_we = 1'b1; b.p1_adrs = 19'h7FFFF; b.p1_wdata = 32'hDEAD_BEEF;
    b.p1_be_N = 4'b1110; b.p1_req = 1'b1;
    dboe_v = 5'd0; wrlo_v = 5'd0; ack1_v = 5'd0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      dboe_v[k-1] = b.mm_dboe;
      wrlo_v[k-1] = ~b.mmwr_N;
      ack1_v[k-1] = b.p1_ack;
      if (k == 1) begin
        check_eq("wr_setup_bus", {b.adrs, b.mmbe_N, b.data_out}, {19'h7FFFF, 4'b1110, 32'hDEAD_BEEF});
      end
      if (k == 4) b.p1_req = 1'b0;
    end
    check_eq("wr_dboe_win", dboe_v, 5'b01111);
    check_eq("wr_strobe_win", wrlo_v, 5'b00110);
    check_eq("wr_ack_win", ack1_v, 5'b01000);
    check_eq("wr_mem", mem_word, 32'h0000_00EF);
    check_eq("wr_rdata_keep", {b.p0_rdata, b.p1_rdata}, {32'h0000_00A5, 32'd0});

    // ---- both ports request continuously: expect 0,1,0,1 five apart ----
    b.data_in = 32'h0BAD_F00D;
    b.p0_we = 1'b0; b.p0_adrs = 19'h00100; b.p0_be_N = 4'b0000;
    b.p1_we = 1'b0; b.p1_adrs = 19'h00200; b.p1_be_N = 4'b0000;
    b.p0_req = 1'b1; b.p1_req = 1'b1;
    nack = 0;
    for (int i = 0; i < 4; i++) begin ack_port[i] = 9; ack_cyc[i] = 0; end
    for (int cyc = 1; cyc <= 40 && nack < 4; cyc++) begin
      tick();
      if (b.p0_ack || b.p1_ack) begin
        ack_port[nack] = b.p1_ack ? 1 : 0;
        ack_cyc[nack]  = cyc;
        nack++;
        if (nack == 4) begin b.p0_req = 1'b0; b.p1_req = 1'b0; end
      end
    end
    check_eq("rr_count", nack, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rr_port%0d", i), ack_port[i], i % 2);
      check_eq($sformatf("rr_cyc%0d", i), ack_cyc[i], 4 + 5 * i);
    end
    tick();
    check_eq("rr_rdata", {b.p0_rdata, b.p1_rdata}, {32'h0BAD_F00D, 32'h0BAD_F00D});

    // ---- reset during STROBE ----
    idle_inputs();
    b.p1_we = 1'b0; b.p1_adrs = 19'h00055; b.p1_be_N = 4'b0000; b.p1_req = 1'b1;
    tick(); tick();
    check_eq("rst_mid_pre", {b.mmrd_N, b.busy}, 2'b01);
    reset_N = 1'b0;
    #1;
    check_eq("rst_mid_strobes", {b.mmrd_N, b.mmwr_N, b.mm_dboe, b.busy}, 4'b1100);
    check_eq("rst_mid_cs", {b.mmcs_N, b.mmbe_N}, 6'b11_1111);
    b.p1_req = 1'b0;
    tick(); tick();
    reset_N = 1'b1;
    acks_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (b.p0_ack || b.p1_ack) acks_seen++;
    end
    check_eq("rst_mid_noack", acks_seen, 0);
    check_eq("rst_mid_rdata", b.p1_rdata, 32'd0);
    b.p0_we = 1'b0; b.p0_adrs = 19'h00001; b.p0_be_N = 4'b0000;
    b.p0_req = 1'b1; b.p1_req = 1'b1;
    nack = 0; ack_port[0] = 9; ack_cyc[0] = 0;
    for (int cyc = 1; cyc <= 10 && nack < 1; cyc++) begin
      tick();
      if (b.p0_ack || b.p1_ack) begin
        ack_port[0] = b.p1_ack ? 1 : 0;
        ack_cyc[0]  = cyc;
        nack++;
        b.p0_req = 1'b0; b.p1_req = 1'b0;
      end
    end
    check_eq("rst_first_port", ack_port[0], 0);
    check_eq("rst_first_cyc", ack_cyc[0], 4);

    // ---- STB=1 and STB=15 builds ----
    tick();
    b1.p0_we = 1'b0; b1.p0_be_N = 4'b0000; b1.p0_req = 1'b1;
    b15.p0_we = 1'b0; b15.p0_be_N = 4'b0000; b15.p0_req = 1'b1;
    lat1 = 0; lat15 = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (b1.p0_ack && lat1 == 0) begin lat1 = k; b1.p0_req = 1'b0; end
      if (b15.p0_ack && lat15 == 0) begin lat15 = k; b15.p0_req = 1'b0; end
    end
    check_eq("stb1_latency", lat1, 3);
    check_eq("stb15_latency", lat15, 17);
    check_eq("stb_rdata", {b1.p0_rdata, b15.p0_rdata}, {32'h0000_0011, 32'h0000_0022});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
